// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall logic for a short scoreboard
// of in-flight writer stages (stage 1 youngest).
module fwd_hazard_unit #(
    parameter int  NUM_STAGES = 2,
    parameter int  LOAD_LAT   = 1,
    localparam int SELW       = $clog2(NUM_STAGES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic            flush,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic            issue_rs1_used,
    input  logic            issue_rs2_used,
    input  logic [4:0]      issue_rd,
    input  logic            issue_rd_we,
    input  logic [1:0]      issue_kind,
    output logic            stall,
    output logic [SELW-1:0] fwd_sel_a,
    output logic [SELW-1:0] fwd_sel_b,
    output logic [1:0]      fwd_kind_a,
    output logic [1:0]      fwd_kind_b,
    output logic [31:0]     stall_cnt
);
    localparam int         CW     = 2;
    localparam logic [1:0] K_LOAD = 2'd1;

    logic [NUM_STAGES-1:0] v_q;
    logic [4:0]            rd_q   [NUM_STAGES];
    logic [1:0]            kind_q [NUM_STAGES];
    logic [CW-1:0]         cnt_q  [NUM_STAGES];
    logic [31:0]           stall_cnt_q;
    logic [31:0]           stall_cnt_d;
    logic                  busy_a;
    logic                  busy_b;
    logic                  insert;
    logic [CW-1:0]         ins_cnt;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        fwd_sel_a  = '0;
        fwd_kind_a = '0;
        busy_a     = 1'b0;
        fwd_sel_b  = '0;
        fwd_kind_b = '0;
        busy_b     = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (issue_rs1_used && issue_rs1 != 5'd0 &&
                v_q[i] && rd_q[i] == issue_rs1) begin
                fwd_sel_a  = SELW'(i + 1);
                fwd_kind_a = kind_q[i];
                busy_a     = cnt_q[i] != '0;
            end
            if (issue_rs2_used && issue_rs2 != 5'd0 &&
                v_q[i] && rd_q[i] == issue_rs2) begin
                fwd_sel_b  = SELW'(i + 1);
                fwd_kind_b = kind_q[i];
                busy_b     = cnt_q[i] != '0;
            end
        end
    end

    always_comb begin
        stall       = issue_valid & ~flush & (busy_a | busy_b);
        insert      = issue_valid & ~flush & ~stall & issue_rd_we &
                      (issue_rd != 5'd0);
        stall_cnt_d = stall_cnt_q + {31'b0, stall};
        ins_cnt     = '0;
        unique case (1'b1)
            (insert && issue_kind == K_LOAD): ins_cnt = CW'(LOAD_LAT);
            default:                          ins_cnt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                rd_q[i]   <= '0;
                kind_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            stall_cnt_q <= stall_cnt_d;
            v_q[0]      <= insert;
            rd_q[0]     <= issue_rd;
            kind_q[0]   <= issue_kind;
            cnt_q[0]    <= ins_cnt;
            for (int i = 1; i < NUM_STAGES; i++) begin
                v_q[i]    <= v_q[i-1];
                rd_q[i]   <= rd_q[i-1];
                kind_q[i] <= kind_q[i-1];
                cnt_q[i]  <= (cnt_q[i-1] == '0) ? '0 : cnt_q[i-1] - CW'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
